// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge-event arbiter: channel mode encodings,
// FSM state type and the per-mode edge qualification helper.
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } evt_state_t;

  // True when the transition prev->cur is an edge this mode cares about.
  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic       prev,
                                    input logic       cur);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = !prev && cur;
      MODE_FALL: hit = prev && !cur;
      MODE_ANY:  hit = prev ^ cur;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event port bundle: valid/ready handshake carrying the channel index and
// the line level captured with the edge.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;

  // Arbiter side: presents events, observes acceptance.
  modport master (
    output evt_valid,
    output evt_ch,
    output evt_level,
    input  evt_ready
  );

  // Consumer side.
  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_level,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter_edge_detect_cell.sv
// One monitored line: registers the previous level, qualifies edges by
// mode and keeps a single pending event (with its level) until granted.
// A new edge on an already pending, non-granted channel is coalesced.
module edge_detect_cell
  import edge_evt_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       x,
  input  logic [1:0] mode,
  input  logic       grant_clr,
  input  logic       mode_clr,
  output logic       pend,
  output logic       pend_lvl,
  output logic       coalesce
);

  logic x_q, x_d;
  logic pend_q, pend_d;
  logic pend_lvl_q, pend_lvl_d;
  logic hit;

  // Pending-state update: disabling the channel beats a new edge, a new
  // edge beats the grant clear of the same cycle.
  always_comb begin
    hit        = edge_hit(mode, x_q, x);
    x_d        = x;
    pend_d     = pend_q;
    pend_lvl_d = pend_lvl_q;
    if (mode_clr) begin
      pend_d = 1'b0;
    end else if (hit) begin
      pend_d     = 1'b1;
      pend_lvl_d = x;
    end else if (grant_clr) begin
      pend_d = 1'b0;
    end
    coalesce = hit && pend_q && !grant_clr && !mode_clr;
  end

  // State registers; the line is still tracked in reset so release is quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q        <= x;
      pend_q     <= 1'b0;
      pend_lvl_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      pend_q     <= pend_d;
      pend_lvl_q <= pend_lvl_d;
    end
  end

  assign pend     = pend_q;
  assign pend_lvl = pend_lvl_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel edge detection, pending
// latches and round-robin serialisation onto one valid/ready event port.
// Optional build macro EDGE_EVT_OVF_CNT_EN adds the ovf_cnt port counting
// cycles in which at least one pending event was coalesced.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CH-1:0]     x,
  input  logic                mode_we,
  input  logic [2*N_CH-1:0]   mode_wdata,
  edge_event_arbiter_if.master evt
`ifdef EDGE_EVT_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0]    ovf_cnt
`endif
);

  localparam int CH_W = $clog2(N_CH);

  evt_state_t        state_q, state_d;
  logic [2*N_CH-1:0] mode_q, mode_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_level_q, evt_level_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   pend_lvl;
  logic [N_CH-1:0]   coalesce;
  logic [N_CH-1:0]   mode_clr;
  logic [N_CH-1:0]   grant_vec;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_en;
  logic              any_pend;

  // First pending channel after ptr, wrapping modulo N_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] p,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = CH_W'((int'(ptr) + off) % N_CH);
      if (!found && p[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign mode_clr[gi] = mode_we && (mode_wdata[2*gi +: 2] == MODE_OFF);

      edge_detect_cell u_cell (
        .clock     (clock),
        .reset     (reset),
        .x         (x[gi]),
        .mode      (mode_q[2*gi +: 2]),
        .grant_clr (grant_vec[gi]),
        .mode_clr  (mode_clr[gi]),
        .pend      (pend[gi]),
        .pend_lvl  (pend_lvl[gi]),
        .coalesce  (coalesce[gi])
      );
    end
  endgenerate

  // Grant selection: a slot opens when idle or when the shown event is taken.
  always_comb begin
    any_pend  = |pend;
    grant_en  = any_pend && ((state_q == ST_IDLE) || evt.evt_ready);
    grant_idx = rr_pick(pend, rr_ptr_q);
    grant_vec = '0;
    if (grant_en) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // Next-state, output-register and mode-register logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_we ? mode_wdata : mode_q;
    evt_ch_d    = evt_ch_q;
    evt_level_d = evt_level_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (evt.evt_ready) state_d = any_pend ? ST_PRESENT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_en) begin
      evt_ch_d    = grant_idx;
      evt_level_d = pend_lvl[grant_idx];
      rr_ptr_d    = grant_idx;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      rr_ptr_q    <= CH_W'(N_CH - 1);
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign evt.evt_valid = (state_q == ST_PRESENT);
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_level = evt_level_q;

`ifdef EDGE_EVT_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of cycles with at least one coalesced edge.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if ((|coalesce) && (ovf_cnt_q != {CNT_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clock) begin
    if (reset) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  // Coalescing is silent in this build.
  wire unused_coalesce = &{1'b0, coalesce};
`endif

endmodule
